// File: rtl/inst_fetch_aligner.sv
// Fetch aligner: pulls 32-bit words from instruction memory into a halfword queue
// and presents complete 16-bit (compressed) or 32-bit instructions with their PC.
module inst_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [15:0] o_low_inst,
  output logic [15:0] o_high_inst,
  output logic        o_inst_valid,
  output logic [31:0] o_pc,
  input  logic        i_ready
);

  logic [15:0] fifo_q [QDEPTH];
  logic [15:0] fifo_d [QDEPTH];
  logic [15:0] shift_s [QDEPTH];
  logic [2:0]  count_q, count_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] faddr_q, faddr_d;
  logic        pending_q, pending_d;
  logic        discard_q, discard_d;
  logic        drop_low_q, drop_low_d;
  logic        started_q;

  logic        head_comp_s;
  logic        valid_s;
  logic        req_s;
  logic        resp_s;
  logic        push_s;
  logic        push_lo_s;
  logic [2:0]  pop_n_s;
  logic [2:0]  push_n_s;
  logic [2:0]  base_s;
  logic [2:0]  hi_idx_s;

  assign head_comp_s = (fifo_q[0][1:0] != 2'b11);
  assign valid_s     = !i_flush && (((count_q >= 3'd1) && head_comp_s) || (count_q >= 3'd2));
  assign req_s       = started_q && !pending_q && (count_q <= 3'd2) && !i_flush;
  assign resp_s      = i_imem_valid && pending_q;
  assign push_s      = resp_s && !discard_q;
  assign push_lo_s   = push_s && !drop_low_q;
  assign pop_n_s     = (valid_s && i_ready) ? (head_comp_s ? 3'd1 : 3'd2) : 3'd0;
  assign push_n_s    = push_s ? (drop_low_q ? 3'd1 : 3'd2) : 3'd0;
  assign base_s      = count_q - pop_n_s;
  // With drop_low the upper halfword lands where the lower one would have gone.
  assign hi_idx_s    = drop_low_q ? base_s : (base_s + 3'd1);

  assign o_imem_req   = req_s;
  assign o_imem_addr  = faddr_q;
  assign o_inst_valid = valid_s;
  assign o_pc         = pc_q;
  assign o_low_inst   = fifo_q[0];
  assign o_high_inst  = (count_q >= 3'd2) ? fifo_q[1] : 16'h0000;

  // Queue contents after removing the consumed instruction.
  always_comb begin
    shift_s = fifo_q;
    case (pop_n_s)
      3'd1:    shift_s = '{fifo_q[1], fifo_q[2], fifo_q[3], 16'h0000};
      3'd2:    shift_s = '{fifo_q[2], fifo_q[3], 16'h0000, 16'h0000};
      default: shift_s = fifo_q;
    endcase
  end

  // Next-state: redirect wins over consume/refill; push lands after the pop.
  always_comb begin
    fifo_d     = fifo_q;
    count_d    = count_q;
    pc_d       = pc_q;
    faddr_d    = faddr_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    drop_low_d = drop_low_q;
    if (i_flush) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_d[i] = 16'h0000;
      end
      count_d    = 3'd0;
      pc_d       = i_flush_pc & ~32'h0000_0001;
      faddr_d    = i_flush_pc & ~32'h0000_0003;
      drop_low_d = i_flush_pc[1];
      if (resp_s) begin
        pending_d = 1'b0;
        discard_d = 1'b0;
      end else if (pending_q) begin
        discard_d = 1'b1;
      end else begin
        discard_d = discard_q;
      end
    end else begin
      pc_d = pc_q + {28'd0, pop_n_s, 1'b0};
      for (int i = 0; i < QDEPTH; i++) begin
        if (push_lo_s && (3'(i) == base_s)) begin
          fifo_d[i] = i_imem_rdata[15:0];
        end else if (push_s && (3'(i) == hi_idx_s)) begin
          fifo_d[i] = i_imem_rdata[31:16];
        end else begin
          fifo_d[i] = shift_s[i];
        end
      end
      count_d = base_s + push_n_s;
      if (resp_s) begin
        pending_d  = 1'b0;
        discard_d  = 1'b0;
        drop_low_d = push_s ? 1'b0 : drop_low_q;
      end else if (req_s) begin
        pending_d = 1'b1;
        faddr_d   = faddr_q + 32'd4;
      end else begin
        pending_d = pending_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= 16'h0000;
      end
      count_q    <= 3'd0;
      pc_q       <= RESET_PC & ~32'h0000_0001;
      faddr_q    <= RESET_PC & ~32'h0000_0003;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
      drop_low_q <= RESET_PC[1];
      started_q  <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      faddr_q    <= faddr_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      drop_low_q <= drop_low_d;
      started_q  <= 1'b1;
    end
  end

endmodule
